// File: rtl/game_flow_pkg.sv
// Shared types and default frame counts for the game-flow controller.
// PAUSED is reachable only when GAME_FLOW_PAUSE_EN is defined.
package game_flow_pkg;

  typedef enum logic [2:0] {
    MENU      = 3'd0,
    LOBBY     = 3'd1,
    COUNTDOWN = 3'd2,
    ACTIVE    = 3'd3,
    VICTORY   = 3'd4,
    DEFEAT    = 3'd5,
    PAUSED    = 3'd6
  } game_state_t;

  localparam int DEF_COUNTDOWN_FRAMES    = 180;
  localparam int DEF_RESULT_FRAMES       = 300;
  localparam int DEF_LINK_TIMEOUT_FRAMES = 60;

  function automatic logic is_result(
    input game_state_t s
  );
    return (s == VICTORY) || (s == DEFEAT);
  endfunction

endpackage

// File: rtl/game_flow_ctrl_link_watchdog.sv
// Per-remote-player link watchdog: counts frames since the last
// valid strobe, saturating at the timeout.
module link_watchdog #(
  parameter  int LINK_TIMEOUT_FRAMES = 60,
  localparam int CW = $clog2(LINK_TIMEOUT_FRAMES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic i_hold,
  input  logic i_tick,
  input  logic i_valid,
  output logic o_lost
);

  localparam logic [CW-1:0] LIMIT = CW'(LINK_TIMEOUT_FRAMES);

  logic [CW-1:0] r_cnt;

  // A valid strobe beats a coincident frame tick.
  always_ff @(posedge clk) begin
    if (rst || i_hold) begin
      r_cnt <= '0;
    end else if (i_valid) begin
      r_cnt <= '0;
    end else if (i_tick && (r_cnt != LIMIT)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_lost = (r_cnt == LIMIT);

endmodule

// File: rtl/game_flow_ctrl.sv
// N-player game-flow FSM: lobby, countdown, watchdogged play, results.
// Define GAME_FLOW_PAUSE_EN to pause play while any remote link is lost.
module game_flow_ctrl
  import game_flow_pkg::*;
#(
  parameter  int NUM_PLAYERS         = 2,
  parameter  int HP_W                = 4,
  parameter  int BOSS_HP_W           = 7,
  parameter  int COUNTDOWN_FRAMES    = DEF_COUNTDOWN_FRAMES,
  parameter  int RESULT_FRAMES       = DEF_RESULT_FRAMES,
  parameter  int LINK_TIMEOUT_FRAMES = DEF_LINK_TIMEOUT_FRAMES,
  localparam int CD_W = $clog2(COUNTDOWN_FRAMES + 1),
  localparam int RS_W = $clog2(RESULT_FRAMES + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        frame_tick,
  input  logic [NUM_PLAYERS-1:0]      player_start,
  input  logic [NUM_PLAYERS*HP_W-1:0] player_hp,
  input  logic [NUM_PLAYERS-1:0]      player_valid,
  input  logic [BOSS_HP_W-1:0]        boss_hp,
  input  logic                        mouse_clicked,
  output logic [2:0]                  game_state,
  output logic                        game_active,
  output logic [CD_W-1:0]             countdown_val,
  output logic [NUM_PLAYERS-1:0]      ready_mask,
  output logic [NUM_PLAYERS-1:0]      alive_mask,
  output logic [NUM_PLAYERS-1:0]      link_lost
);

  game_state_t r_state;
  game_state_t w_next;

  logic [CD_W-1:0]        r_cd;
  logic [RS_W-1:0]        r_res;
  logic                   r_armed;
  logic                   r_active;
  logic [NUM_PLAYERS-1:0] r_ready;
  logic [NUM_PLAYERS-1:0] r_alive;

  logic [NUM_PLAYERS-1:0] w_hp_nz;
  logic [NUM_PLAYERS-1:0] w_alive;
  logic [NUM_PLAYERS-1:0] w_lost;
  logic                   w_hold;
  logic                   w_all_ready;
  logic                   w_cd_done;
  logic                   w_res_done;
  logic                   w_click;
  logic                   w_boss_dead;
  logic                   w_unused;

  assign w_unused = player_valid[0];

  always_comb begin
    w_hp_nz = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      w_hp_nz[i] = |player_hp[i*HP_W +: HP_W];
    end
  end

  assign w_alive     = w_hp_nz & ~w_lost;
  assign w_hold      = (r_state == MENU);
  assign w_all_ready = &r_ready;
  assign w_boss_dead = (boss_hp == '0);
  assign w_cd_done   = frame_tick && (r_cd <= CD_W'(1));
  assign w_res_done  = frame_tick && (r_res <= RS_W'(1));
  // Armed only after a low level in this state, so armed & high = edge.
  assign w_click     = r_armed && mouse_clicked;

  assign w_lost[0] = 1'b0;

  for (genvar gi = 1; gi < NUM_PLAYERS; gi++) begin : g_wd
    link_watchdog #(
      .LINK_TIMEOUT_FRAMES(LINK_TIMEOUT_FRAMES)
    ) u_wd (
      .clk     (clk),
      .rst     (rst),
      .i_hold  (w_hold),
      .i_tick  (frame_tick),
      .i_valid (player_valid[gi]),
      .o_lost  (w_lost[gi])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= MENU;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      MENU: begin
        if (player_start[0]) w_next = LOBBY;
      end
      LOBBY: begin
        if (w_all_ready) w_next = COUNTDOWN;
      end
      COUNTDOWN: begin
        if (w_cd_done) w_next = ACTIVE;
      end
      ACTIVE: begin
        if (w_boss_dead) begin
          w_next = VICTORY;
`ifdef GAME_FLOW_PAUSE_EN
        end else if (|w_lost) begin
          w_next = PAUSED;
`endif
        end else if (w_alive == '0) begin
          w_next = DEFEAT;
        end
      end
      PAUSED: begin
`ifdef GAME_FLOW_PAUSE_EN
        if (w_boss_dead) begin
          w_next = VICTORY;
        end else if (w_lost == '0) begin
          w_next = ACTIVE;
        end
`else
        w_next = MENU;
`endif
      end
      VICTORY, DEFEAT: begin
        if (w_res_done || w_click) w_next = MENU;
      end
      default: w_next = MENU;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cd     <= '0;
      r_res    <= '0;
      r_armed  <= 1'b0;
      r_active <= 1'b0;
      r_ready  <= '0;
      r_alive  <= '0;
    end else begin
      r_active <= (w_next == ACTIVE);
      // Liveness tracks play and is frozen everywhere else.
      if ((r_state == ACTIVE) || (w_next == ACTIVE)) begin
        r_alive <= w_alive;
      end
      unique case (r_state)
        MENU: begin
          if (player_start[0]) r_ready[0] <= 1'b1;
        end
        LOBBY: begin
          if (w_all_ready) begin
            r_cd <= CD_W'(COUNTDOWN_FRAMES);
          end else begin
            r_ready <= (r_ready | player_start) & ~w_lost;
          end
        end
        COUNTDOWN: begin
          if (w_cd_done) begin
            r_cd <= '0;
          end else if (frame_tick) begin
            r_cd <= r_cd - 1'b1;
          end
        end
        VICTORY, DEFEAT: begin
          if (w_next == MENU) begin
            r_res   <= '0;
            r_armed <= 1'b0;
            r_ready <= '0;
            r_alive <= '0;
          end else begin
            if (frame_tick) r_res <= r_res - 1'b1;
            if (!mouse_clicked) r_armed <= 1'b1;
          end
        end
        default: ;
      endcase
      if (is_result(w_next) && (w_next != r_state)) begin
        r_res   <= RS_W'(RESULT_FRAMES);
        r_armed <= 1'b0;
      end
    end
  end

  assign game_state    = r_state;
  assign game_active   = r_active;
  assign countdown_val = r_cd;
  assign ready_mask    = r_ready;
  assign alive_mask    = r_alive;
  assign link_lost     = w_lost;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Self-checking bench for game_flow_ctrl: rule-level model + directed cases.
// Also follows the PAUSED path when GAME_FLOW_PAUSE_EN is defined.
module tb_game_flow_ctrl;
  import game_flow_pkg::*;

  localparam int NP  = 2;
  localparam int HPW = 4;
  localparam int BW  = 7;
  localparam int CDF = 180;
  localparam int RF  = 300;
  localparam int LTO = 60;

  logic          clk = 1'b0;
  logic          rst;
  logic          tick;
  logic [NP-1:0] start;
  logic [NP*HPW-1:0] hp;
  logic [NP-1:0] valid;
  logic [BW-1:0] boss;
  logic          mouse;
  logic [2:0]    st;
  logic          act;
  logic [7:0]    cdv;
  logic [NP-1:0] rdy;
  logic [NP-1:0] alv;
  logic [NP-1:0] lost;

  int n_chk = 0;
  int n_err = 0;
  bit keep;

  game_flow_ctrl #(
    .NUM_PLAYERS(NP), .HP_W(HPW), .BOSS_HP_W(BW),
    .COUNTDOWN_FRAMES(CDF), .RESULT_FRAMES(RF),
    .LINK_TIMEOUT_FRAMES(LTO)
  ) dut (
    .clk(clk), .rst(rst), .frame_tick(tick),
    .player_start(start), .player_hp(hp),
    .player_valid(valid), .boss_hp(boss),
    .mouse_clicked(mouse), .game_state(st),
    .game_active(act), .countdown_val(cdv),
    .ready_mask(rdy), .alive_mask(alv),
    .link_lost(lost)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int a, input int e);
    n_chk++;
    if (a != e) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, a, e, $time);
    end
  endtask

  // Model: game rules over plain integers.
  game_state_t m_st;
  int m_cd, m_res;
  int m_wd [NP];
  bit m_armed, m_on;
  logic [NP-1:0] m_ready, m_alive, m_lost;
  logic [NP-1:0] e_lost, e_alive;
  game_state_t nx;
  bit fin;

  always @(posedge clk) begin
    for (int i = 0; i < NP; i++) begin
      e_lost[i]  = (i > 0) && (m_wd[i] == LTO);
      e_alive[i] = (hp[i*HPW +: HPW] != 0) && !e_lost[i];
    end
    if (rst) begin
      m_st = MENU; m_cd = 0; m_res = 0; m_armed = 0;
      m_ready = 0; m_alive = 0;
      for (int i = 0; i < NP; i++) m_wd[i] = 0;
      m_on = 1;
    end else begin
      nx = m_st;
      case (m_st)
        MENU: if (start[0]) begin
          nx = LOBBY; m_ready[0] = 1;
        end
        LOBBY: if (m_ready == {NP{1'b1}}) begin
          nx = COUNTDOWN; m_cd = CDF;
        end else m_ready = (m_ready | start) & ~e_lost;
        COUNTDOWN: if (tick) begin
          if (m_cd <= 1) begin nx = ACTIVE; m_cd = 0; end
          else m_cd = m_cd - 1;
        end
        ACTIVE: begin
          if (boss == 0) nx = VICTORY;
`ifdef GAME_FLOW_PAUSE_EN
          else if (e_lost != 0) nx = PAUSED;
`endif
          else if (e_alive == 0) nx = DEFEAT;
        end
        PAUSED: begin
`ifdef GAME_FLOW_PAUSE_EN
          if (boss == 0) nx = VICTORY;
          else if (e_lost == 0) nx = ACTIVE;
`else
          nx = MENU;
`endif
        end
        VICTORY, DEFEAT: begin
          fin = (tick && m_res <= 1) || (m_armed && mouse);
          if (fin) begin
            nx = MENU; m_ready = 0; m_alive = 0; m_res = 0;
            m_armed = 0;
          end else begin
            if (tick) m_res = m_res - 1;
            if (!mouse) m_armed = 1;
          end
        end
        default: nx = MENU;
      endcase
      if (m_st == ACTIVE || nx == ACTIVE) m_alive = e_alive;
      if ((nx == VICTORY || nx == DEFEAT) && nx != m_st) begin
        m_res = RF; m_armed = 0;
      end
      for (int i = 1; i < NP; i++) begin
        if (m_st == MENU || valid[i]) m_wd[i] = 0;
        else if (tick && m_wd[i] < LTO) m_wd[i]++;
      end
      m_st = nx;
    end
    for (int i = 0; i < NP; i++)
      m_lost[i] = (i > 0) && (m_wd[i] == LTO);
  end

  always @(negedge clk) begin
    if (m_on) begin
      chk("state",     int'(st),   int'(m_st));
      chk("active",    int'(act),  int'(m_st == ACTIVE));
      chk("countdown", int'(cdv),  m_cd);
      chk("ready",     int'(rdy),  int'(m_ready));
      chk("alive",     int'(alv),  int'(m_alive));
      chk("link_lost", int'(lost), int'(m_lost));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    repeat (n) begin
      tick = 1'b1;
      if (keep) valid = 2'b10;
      step();
      tick = 1'b0;
      valid = '0;
      step();
    end
  endtask

  task automatic go_countdown();
    start = 2'b01; step();
    start = 2'b11; step(); step();
    start = 2'b00;
    chk("lit_cd_entry", int'(cdv), 180);
  endtask

  task automatic go_active();
    go_countdown();
    tick_n(180);
    chk("lit_active", int'(st), 3);
  endtask

  initial begin
    rst = 1; tick = 0; start = 0; valid = 0;
    mouse = 0; boss = 7'd50; keep = 1;
    hp = {4'd5, 4'd5};
    step(); step();
    rst = 0;
    chk("lit_rst_state", int'(st), 0);
    chk("lit_rst_ready", int'(rdy), 0);
    chk("lit_rst_cd", int'(cdv), 0);

    // Lobby with remote joining five cycles later.
    start = 2'b01; step();
    chk("lit_lobby", int'(st), 1);
    chk("lit_lobby_rdy", int'(rdy), 1);
    repeat (4) step();
    start = 2'b11; step();
    chk("lit_rdy_all", int'(rdy), 3);
    step();
    start = 2'b00;
    chk("lit_cd_state", int'(st), 2);
    chk("lit_cd_load", int'(cdv), 180);
    tick_n(179);
    chk("lit_cd_last", int'(cdv), 1);
    chk("lit_cd_hold", int'(st), 2);
    tick_n(1);
    chk("lit_act_state", int'(st), 3);
    chk("lit_act_flag", int'(act), 1);
    chk("lit_act_alive", int'(alv), 3);

    // One player down, then both down.
    hp = {4'd3, 4'd0}; step();
    chk("lit_alive_10", int'(alv), 2);
    chk("lit_still_act", int'(st), 3);
    hp = {4'd0, 4'd0}; step();
    chk("lit_defeat", int'(st), 5);
    step();
    mouse = 1; step();
    chk("lit_click_menu", int'(st), 0);
    mouse = 0; hp = {4'd5, 4'd5};

    // Boss and party die together, then timed return.
    go_active();
    boss = 0; hp = {4'd0, 4'd0}; step();
    chk("lit_victory", int'(st), 4);
    boss = 7'd50; hp = {4'd5, 4'd5};
    tick_n(299);
    chk("lit_vic_hold", int'(st), 4);
    tick_n(1);
    chk("lit_res_menu", int'(st), 0);
    chk("lit_res_rdy", int'(rdy), 0);

    // Click held across the transition must not exit.
    go_active();
    mouse = 1; step();
    boss = 0; step();
    chk("lit_vic2", int'(st), 4);
    repeat (3) step();
    chk("lit_held_click", int'(st), 4);
    mouse = 0; step();
    chk("lit_release", int'(st), 4);
    mouse = 1; step();
    chk("lit_edge_menu", int'(st), 0);
    mouse = 0; boss = 7'd50;

    // Remote link goes silent.
    go_active();
    keep = 0;
    tick_n(59);
    chk("lit_lost_pre", int'(lost), 0);
    tick_n(1);
    chk("lit_lost", int'(lost), 2);
    chk("lit_lost_alive", int'(alv), 1);
`ifdef GAME_FLOW_PAUSE_EN
    chk("lit_paused", int'(st), 6);
    chk("lit_paused_act", int'(act), 0);
`else
    chk("lit_lost_act", int'(st), 3);
`endif
    valid = 2'b10; step(); valid = 0;
    chk("lit_relink", int'(lost), 0);
`ifdef GAME_FLOW_PAUSE_EN
    step();
    chk("lit_resume", int'(st), 3);
`endif
    keep = 1;
    rst = 1; step(); rst = 0;
    chk("lit_rst_act", int'(st), 0);

    // Reset mid-countdown.
    go_countdown();
    tick_n(83);
    chk("lit_cd_97", int'(cdv), 97);
    rst = 1; step();
    chk("lit_rst2_state", int'(st), 0);
    chk("lit_rst2_act", int'(act), 0);
    chk("lit_rst2_cd", int'(cdv), 0);
    chk("lit_rst2_rdy", int'(rdy), 0);
    chk("lit_rst2_alv", int'(alv), 0);
    chk("lit_rst2_lost", int'(lost), 0);
    rst = 0; step(); step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
